dm_access: RTL

Data-memory access stage that sits directly downstream of the data address generator. It consumes the DM address produced each cycle, performs single-cycle-issue reads and posted writes against an internal single-port data memory, and returns read data to the bus-connect path. A one-entry posted-write buffer with store-to-load forwarding hides the single memory port, so the stage never stalls the sequencer.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_wbuf.sv | 48 ++++
 rtl/dm_access.sv | 76 +++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access stage.
package dm_pkg;

    localparam int unsigned DM_DW    = 16;
    localparam int unsigned DM_AW    = 16;
    localparam int unsigned DM_DEPTH = 1024;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_RD   = 2'd1,
        DM_WR   = 2'd2
    } dm_acc_e;

endpackage

// File: rtl/dm_wbuf.sv
// One-entry posted-write buffer: holds the pending write, compares for
// store-to-load forwarding and decides when the entry commits to memory.
module dm_wbuf import dm_pkg::*; #(
    parameter int unsigned IW = 10,
    parameter int unsigned DW = DM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  dm_acc_e       acc,
    input  logic [IW-1:0] add,
    input  logic [DW-1:0] wdt,
    output logic          hit_c,
    output logic [DW-1:0] wb_dt,
    output logic          mem_we_c,
    output logic [IW-1:0] mem_add_c,
    output logic [DW-1:0] mem_dt_c
);

    logic          wb_vld;
    logic [IW-1:0] wb_add;

    // Reads own the memory port; any other cycle retires a pending entry.
    always_comb begin
        hit_c     = wb_vld && (wb_add == add);
        mem_we_c  = rst_n && wb_vld && (acc != DM_RD);
        mem_add_c = wb_add;
        mem_dt_c  = wb_dt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_vld <= 1'b0;
            wb_add <= '0;
            wb_dt  <= '0;
        end else begin
            case (acc)
                DM_WR: begin
                    wb_vld <= 1'b1;
                    wb_add <= add;
                    wb_dt  <= wdt;
                end
                DM_IDLE: wb_vld <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dm_access.sv
// Data-memory access stage: single-port memory behind a posted-write buffer,
// one-cycle read latency, sticky out-of-range flag.
module dm_access import dm_pkg::*; #(
    parameter int unsigned DEPTH = DM_DEPTH,
    parameter int unsigned DW    = DM_DW,
    parameter int unsigned AW    = DM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps_dm_en,
    input  logic          ps_dm_wrt,
    input  logic [AW-1:0] dg_dm_add,
    input  logic [DW-1:0] bc_dt_out,
    output logic [DW-1:0] dm_bc_dt,
    output logic          dm_bc_vld,
    output logic          dm_ps_oob
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [IW-1:0] idx_c;
    logic          oob_c;
    dm_acc_e       acc_c;
    logic [DW-1:0] rd_dt_c;
    logic          hit_c;
    logic [DW-1:0] wb_dt;
    logic          mem_we_c;
    logic [IW-1:0] mem_add_c;
    logic [DW-1:0] mem_dt_c;

    // An out-of-range write is dropped, so the buffer sees it as an idle cycle.
    always_comb begin
        idx_c = dg_dm_add[IW-1:0];
        oob_c = ({1'b0, dg_dm_add} >= (AW+1)'(DEPTH));
        acc_c = DM_IDLE;
        if (ps_dm_en) begin
            if (!ps_dm_wrt)  acc_c = DM_RD;
            else if (!oob_c) acc_c = DM_WR;
        end
        if (oob_c)      rd_dt_c = '0;
        else if (hit_c) rd_dt_c = wb_dt;
        else            rd_dt_c = mem[idx_c];
    end

    dm_wbuf #(.IW(IW), .DW(DW)) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc       (acc_c),
        .add       (idx_c),
        .wdt       (bc_dt_out),
        .hit_c     (hit_c),
        .wb_dt     (wb_dt),
        .mem_we_c  (mem_we_c),
        .mem_add_c (mem_add_c),
        .mem_dt_c  (mem_dt_c)
    );

    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_add_c] <= mem_dt_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dm_bc_dt  <= '0;
            dm_bc_vld <= 1'b0;
            dm_ps_oob <= 1'b0;
        end else begin
            dm_bc_vld <= (acc_c == DM_RD);
            if (acc_c == DM_RD) dm_bc_dt <= rd_dt_c;
            if (ps_dm_en && oob_c) dm_ps_oob <= 1'b1;
        end
    end

endmodule
